add_round_key_stage: RTL
========================

Name: add_round_key_stage

Overview:
- Byte-serial AddRoundKey stage that sits directly downstream of the round-key expander.
- Captures the 16-byte cipher state from the preceding MixColumns stage.
- Raises round_complete so the key expander releases its round key, then XORs each incoming key byte with the stored state byte.
- Streams the 16 result bytes to the next round.

Parameters:
NBYTES, 16, bytes per block (state and key); counters sized $clog2(NBYTES)+1
DW, 8, byte width

Ports:
clk  in  1  rising-edge clock, sole clock domain
rst  in  1  synchronous active-high reset
state_in  in  DW  cipher state byte, column-major order (byte 0 first)
state_valid  in  1  state_in valid this cycle
key_in  in  DW  round-key byte from key expander dout
key_valid  in  1  key_in valid (key expander enable_out)
round_complete  out  1  level; high while waiting for key; drives key expander round_complete
dout  out  DW  state XOR key byte
dout_valid  out  1  dout valid this cycle
done  out  1  one-cycle pulse after 16th output byte
busy  out  1  high in any state except S_LOAD_ST with st_cnt==0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): state<=S_LOAD_ST, st_cnt<=0, k_cnt<=0.
  - round_complete, dout_valid, done <= 0; dout <= 8'h00.
  - st_mem contents are don't-care.
  - Reset mid-operation aborts the round and discards all captured bytes; the next round starts cleanly.
- S_LOAD_ST:
  - state_valid=1: st_mem[st_cnt]<=state_in, st_cnt++. Gaps in state_valid are allowed.
  - Same edge that writes byte NBYTES-1: st_cnt<=0, next state S_WAIT_KEY, round_complete<=1.
  - key_valid is ignored here.
- S_WAIT_KEY:
  - round_complete held 1. It must stay high until the first key byte, because the expander needs ≥3 cycles of round_complete.
  - state_valid is ignored.
  - key_valid=1: process key byte 0 (see streaming rule), k_cnt<=1, round_complete<=0, go S_STREAM.
- S_STREAM:
  - Streaming rule: on each key_valid=1 edge, dout<=st_mem[k_cnt]^key_in and dout_valid<=1. Latency is exactly 1 cycle, key byte to dout.
  - key_valid=0: dout_valid<=0 and dout holds its value. Gaps are allowed.
  - On the edge processing byte NBYTES-1: go S_DONE.
- S_DONE:
  - One cycle: done<=1, dout_valid<=0, k_cnt<=0, go S_LOAD_ST.
  - key_valid is ignored; extra expander bytes are dropped.
- state_valid arriving in S_STREAM or S_DONE is dropped. Upstream must not send the next block until done.
- Output byte order equals key/state byte order, index 0..15.
- Width rules: XOR is DW bits, no carry. Counters never wrap past NBYTES; they are cleared explicitly.

Optional Feature:
- Macro ARK_KEY_PASSTHRU_EN adds ports key_out (out, DW) and key_out_valid (out, 1).
- With the macro: each accepted key byte is re-registered, so key_out<=key_in and key_out_valid<=1 on the same edge as dout. This feeds the next round's key expander din/enable_din.
  - key_out_valid=0 otherwise; both outputs reset to 0.
- Without the macro: the ports are absent and there is no extra logic.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NBYTES=16 and AES_DW=8;
  - the ark_state_t enum: S_LOAD_ST=0, S_WAIT_KEY=1, S_STREAM=2, S_DONE=3;
  - the byte_t typedef.
- One natural sub-module: ark_byte_buf, a 16x8 register file with write port (we, waddr, wdata) and async read (raddr, rdata).
- The FSM and XOR stay in the top level.

Test Plan:
1. Reset, then state bytes 0x00..0x0F on consecutive cycles, round_complete high, then key 0xA0..0xAF consecutive -> 16 consecutive dout=0xA0, each 1 cycle after its key byte; done pulses 1 cycle after the last byte.
2. state_valid toggling 1/0, key_valid with 2-cycle gaps; state 0xFF, key 0x0F -> every dout=0xF0, dout_valid only on the cycles after key_valid, dout held during gaps.
3. round_complete hold: after state load, delay key_valid 10 cycles -> round_complete stays 1 for all 10 cycles; drops the cycle after the first key byte.
4. Reset asserted after 8 key bytes -> next cycle all outputs 0 and state S_LOAD_ST. A fresh full round then yields correct results with no stale bytes.
5. Protocol violations: key_valid during S_LOAD_ST, and a 17th key byte in S_DONE -> both ignored, no dout_valid, next round unaffected.
6. With ARK_KEY_PASSTHRU_EN, key bytes 0x11..0x20 -> key_out is 0x11..0x20, cycle-aligned with dout_valid.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types: block geometry, byte type and AddRoundKey FSM states.
package aes_pkg;
    localparam int AES_NBYTES = 16;
    localparam int AES_DW     = 8;

    typedef logic [AES_DW-1:0] byte_t;

    typedef enum logic [1:0] {
        S_LOAD_ST  = 2'd0,
        S_WAIT_KEY = 2'd1,
        S_STREAM   = 2'd2,
        S_DONE     = 2'd3
    } ark_state_t;
endpackage

// File: rtl/ark_byte_buf.sv
// State byte register file: one synchronous write port, one asynchronous read port.
module ark_byte_buf #(
    parameter int NBYTES = 16,
    parameter int DW     = 8,
    parameter int AW     = $clog2(NBYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    // Contents are never reset; the FSM always rewrites all bytes before reading.
    logic [DW-1:0] mem_q [NBYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/add_round_key_stage.sv
// Byte-serial AddRoundKey: capture 16 state bytes, request the round key, stream state^key.
// Optional key re-register outputs are enabled by defining ARK_KEY_PASSTHRU_EN.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_NBYTES,
    parameter int DW     = AES_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] state_in,
    input  logic          state_valid,
    input  logic [DW-1:0] key_in,
    input  logic          key_valid,
    output logic          round_complete,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          done,
`ifdef ARK_KEY_PASSTHRU_EN
    output logic [DW-1:0] key_out,
    output logic          key_out_valid,
`endif
    output logic          busy
);
    localparam int CW = $clog2(NBYTES) + 1;
    localparam int AW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    ark_state_t    state_q, state_d;
    logic [CW-1:0] st_cnt_q, st_cnt_d;
    logic [CW-1:0] k_cnt_q, k_cnt_d;
    logic          rc_q, rc_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          done_q, done_d;
    logic          we;
    logic          key_fire;
    logic [DW-1:0] rdata;

    ark_byte_buf #(.NBYTES(NBYTES), .DW(DW)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (st_cnt_q[AW-1:0]),
        .wdata (state_in),
        .raddr (k_cnt_q[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        state_d      = state_q;
        st_cnt_d     = st_cnt_q;
        k_cnt_d      = k_cnt_q;
        rc_d         = rc_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        done_d       = 1'b0;
        we           = 1'b0;
        key_fire     = 1'b0;
        case (state_q)
            S_LOAD_ST: begin
                if (state_valid) begin
                    we = 1'b1;
                    if (st_cnt_q == LAST) begin
                        st_cnt_d = '0;
                        rc_d     = 1'b1;
                        state_d  = S_WAIT_KEY;
                    end else begin
                        st_cnt_d = st_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_KEY: begin
                // Expander needs round_complete held until it starts emitting key bytes.
                rc_d = 1'b1;
                if (key_valid) begin
                    key_fire = 1'b1;
                    rc_d     = 1'b0;
                    k_cnt_d  = CW'(1);
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (key_valid) begin
                    key_fire = 1'b1;
                    if (k_cnt_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        k_cnt_d = k_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                k_cnt_d = '0;
                state_d = S_LOAD_ST;
            end
            default: state_d = S_LOAD_ST;
        endcase
        if (key_fire) begin
            dout_d       = rdata ^ key_in;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD_ST;
            st_cnt_q     <= '0;
            k_cnt_q      <= '0;
            rc_q         <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            st_cnt_q     <= st_cnt_d;
            k_cnt_q      <= k_cnt_d;
            rc_q         <= rc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef ARK_KEY_PASSTHRU_EN
    logic [DW-1:0] key_out_q, key_out_d;
    logic          key_out_valid_q, key_out_valid_d;

    always_comb begin
        key_out_d       = key_fire ? key_in : key_out_q;
        key_out_valid_d = key_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_out_q       <= '0;
            key_out_valid_q <= 1'b0;
        end else begin
            key_out_q       <= key_out_d;
            key_out_valid_q <= key_out_valid_d;
        end
    end

    assign key_out       = key_out_q;
    assign key_out_valid = key_out_valid_q;
`endif

    assign round_complete = rc_q;
    assign dout           = dout_q;
    assign dout_valid     = dout_valid_q;
    assign done           = done_q;
    assign busy           = !(state_q == S_LOAD_ST && st_cnt_q == '0);
endmodule
